// File: rtl/hcf_sequencer.sv
// Highest common factor by repeated subtraction; one subtraction per cycle, result held until result_ready.
// Latency N+1 edges from accept; HCF_ITER_COUNT_EN adds the saturating iter_count output.
module hcf_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic [7:0] result,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       busy,
    output logic       zero_err
`ifdef HCF_ITER_COUNT_EN
    ,
    output logic [7:0] iter_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_result;
    logic       r_zero_err;
    logic       w_accept;
    logic       w_finish;

    assign w_accept = (r_state == S_IDLE) && start_valid;
    // Terminal condition also covers a zero operand, so the loop always ends.
    assign w_finish = (r_a == 8'd0) || (r_b == 8'd0) || (r_a == r_b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_valid) w_next = S_CALC;
            S_CALC: if (w_finish) w_next = S_DONE;
            S_DONE: if (result_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a        <= 8'd0;
            r_b        <= 8'd0;
            r_result   <= 8'd0;
            r_zero_err <= 1'b0;
        end else if (w_accept) begin
            r_a <= a_in;
            r_b <= b_in;
        end else if (r_state == S_CALC) begin
            if (w_finish) begin
                r_result   <= r_a | r_b;
                r_zero_err <= (r_a == 8'd0) && (r_b == 8'd0);
            end else if (r_a > r_b) begin
                r_a <= r_a - r_b;
            end else begin
                r_b <= r_b - r_a;
            end
        end
    end

`ifdef HCF_ITER_COUNT_EN
    logic [7:0] r_iter;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_iter <= 8'd0;
        end else if (w_accept) begin
            r_iter <= 8'd0;
        end else if ((r_state == S_CALC) && !w_finish && (r_iter != 8'hFF)) begin
            r_iter <= r_iter + 8'd1;
        end
    end

    assign iter_count = r_iter;
`endif

    // Handshake outputs decode the registered state only: no result_ready -> start_ready path.
    assign start_ready  = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign result_valid = (r_state == S_DONE);
    assign result       = r_result;
    assign zero_err     = r_zero_err;

endmodule

// File: tb/tb_hcf_sequencer.sv
// Scoreboard bench for hcf_sequencer: accepts are predicted from a subtraction model, results checked on completion.
module tb_hcf_sequencer;

    logic       clk;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       busy;
    logic       zero_err;
`ifdef HCF_ITER_COUNT_EN
    logic [7:0] iter_count;
`endif

    hcf_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .zero_err     (zero_err)
`ifdef HCF_ITER_COUNT_EN
        ,
        .iter_count   (iter_count)
`endif
    );

    typedef struct {
        logic [7:0] res;
        logic       z;
        int         n;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec;
    int         n_bad;
    int         cyc;
    logic       seen;
    logic       hs_prev;
    logic [7:0] last_res;
    logic       last_z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void hcf_model(input logic [7:0] a, input logic [7:0] b,
                                      output logic [7:0] r, output logic z, output int n);
        z = (a == 8'd0) && (b == 8'd0);
        n = 0;
        while (!((a == 8'd0) || (b == 8'd0) || (a == b))) begin
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        r = a | b;
    endfunction

    // Monitor: predict on accept, compare while result_valid, verify the cycle after each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (hs_prev) begin
            chk("post_hs_start_ready", start_ready, 1);
            chk("post_hs_valid", result_valid, 0);
            chk("post_hs_result_hold", result, last_res);
            chk("post_hs_zero_err_hold", zero_err, last_z);
            hs_prev = 1'b0;
        end
        if (reset && start_valid && start_ready) begin
            hcf_model(a_in, b_in, e.res, e.z, e.n);
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result_valid", result_valid, 0);
            end else begin
                e = exp_q[0];
                if (!seen) begin
                    chk("latency", cyc - e.acc, e.n + 1);
`ifdef HCF_ITER_COUNT_EN
                    chk("iter_count", iter_count, (e.n > 255) ? 255 : e.n);
`endif
                    seen = 1'b1;
                end
                chk("result", result, e.res);
                chk("zero_err", zero_err, e.z);
                chk("busy_in_done", busy, 1);
                chk("start_ready_in_done", start_ready, 0);
                if (result_ready) begin
                    last_res = e.res;
                    last_z   = e.z;
                    void'(exp_q.pop_front());
                    seen    = 1'b0;
                    hs_prev = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit keep);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        a_in        = a;
        b_in        = b;
        start_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (start_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", start_ready, 1);
        @(posedge clk);
        #1;
        if (!keep) start_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_zero_err"}, zero_err, 0);
        chk({tag, "_start_ready"}, start_ready, 1);
`ifdef HCF_ITER_COUNT_EN
        chk({tag, "_iter_count"}, iter_count, 0);
`endif
    endtask

    initial begin
        n_vec        = 0;
        n_bad        = 0;
        seen         = 1'b0;
        hs_prev      = 1'b0;
        last_res     = 8'd0;
        last_z       = 1'b0;
        reset        = 1'b0;
        start_valid  = 1'b0;
        a_in         = 8'd0;
        b_in         = 8'd0;
        result_ready = 1'b1;

        #22;
        check_reset_outputs("reset");
        reset = 1'b1;

        // Directed vectors with an always-ready consumer.
        send(8'd12, 8'd18, 1'b0);   drain();
        send(8'd255, 8'd1, 1'b0);   drain();
        send(8'd0, 8'd0, 1'b0);     drain();
        send(8'd0, 8'd9, 1'b0);     drain();

        // Consumer stalls; start_valid pulses in DONE must be ignored.
        result_ready = 1'b0;
        send(8'd35, 8'd14, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (result_valid) break;
        end
        chk("stall_valid_seen", result_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a_in        = 8'd3;
            b_in        = 8'd5;
            start_valid = (i % 2 == 0);
        end
        @(posedge clk);
        #1;
        start_valid  = 1'b0;
        result_ready = 1'b1;
        drain();

        // Reset in the middle of a calculation discards the job.
        send(8'd200, 8'd150, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midcalc_reset");
        exp_q.delete();
        seen    = 1'b0;
        hs_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held_no_valid", result_valid, 0);
        reset = 1'b1;
        send(8'd8, 8'd12, 1'b0);    drain();

        // Back-to-back jobs with start_valid and result_ready held high.
        send(8'd9, 8'd6, 1'b1);
        send(8'd21, 8'd28, 1'b0);
        drain();

        for (int k = 0; k < 16; k++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
            drain();
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
